// File: rtl/fft_iter_engine_if.sv
// Stream, control and twiddle-port bundle for fft_iter_engine.
// The master side is the surrounding system (sample source, bin sink, twiddle ROM).
// The slave side is the FFT engine itself.
interface fft_iter_engine_if #(
    parameter int DW    = 16,
    parameter int LOG2N = 6,
    parameter int TW    = 10
);
    logic                    start;
    logic                    busy;
    logic                    done;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_re;
    logic signed [DW-1:0]    in_im;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;
    logic [LOG2N-1:0]        out_index;

    logic [LOG2N-2:0]        tw_addr;
    logic signed [TW-1:0]    tw_re;
    logic signed [TW-1:0]    tw_im;

    modport master (
        output start, in_valid, in_re, in_im, out_ready, tw_re, tw_im,
        input  busy, done, in_ready, out_valid, out_re, out_im, out_index, tw_addr
    );

    modport slave (
        input  start, in_valid, in_re, in_im, out_ready, tw_re, tw_im,
        output busy, done, in_ready, out_valid, out_re, out_im, out_index, tw_addr
    );
endinterface

// File: rtl/fft_iter_engine.sv
// Iterative in-place radix-2 DIT FFT engine.
// Samples are loaded in bit-reversed order into a register array, LOG2N stages of
// N/2 butterflies run one per cycle, then bins are streamed out in natural order.
// Twiddles are fetched combinationally through the tw_addr/tw_re/tw_im port.
// Optional build macro FFT_STAGE_SCALE_EN: halve every butterfly result (output = DFT/N).
module fft_iter_engine #(
    parameter int N     = 64,
    parameter int LOG2N = 6,
    parameter int DW    = 16,
    parameter int TW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    fft_iter_engine_if.slave bus
);
    localparam int SW = $clog2(LOG2N + 1);
    localparam int MW = DW + TW;
    localparam logic [LOG2N-1:0] ONE  = 1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_UNLOAD} state_t;

    state_t           state_q, state_d;
    // Sample index in LOAD, butterfly pair j in CALC (MSB stays 0), bin index in UNLOAD.
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    stage_q, stage_d;

    logic signed [DW-1:0] mem_re_q [N];
    logic signed [DW-1:0] mem_im_q [N];

    logic [LOG2N-1:0] load_addr;
    logic [LOG2N-1:0] pair_j, half, pos, addr_a, addr_b, tw_full;
    logic             load_we, calc_we;

    logic signed [DW-1:0]   a_re, a_im, b_re, b_im;
    logic signed [MW-1:0]   m_rr, m_ii, m_ri, m_ir;
    logic signed [MW:0]     p_re, p_im;
    logic signed [DW+1:0]   t_re, t_im, sum_re, sum_im, dif_re, dif_im;
    logic signed [DW-1:0]   wa_re, wa_im, wb_re, wb_im;

    logic                   busy_c, done_c, in_ready_c, out_valid_c;
    logic signed [DW-1:0]   out_re_c, out_im_c;
    logic [LOG2N-1:0]       out_index_c;
    logic [LOG2N-2:0]       tw_addr_c;

    // Bit-reversed write address for the incoming sample.
    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign load_addr[gi] = cnt_q[LOG2N-1-gi];
        end
    endgenerate

    // Butterfly operand addresses and twiddle index for pair j of the current stage.
    always_comb begin
        pair_j  = {1'b0, cnt_q[LOG2N-2:0]};
        half    = ONE << stage_q;
        pos     = pair_j & (half - ONE);
        addr_a  = ((pair_j >> stage_q) << (stage_q + SW'(1))) | pos;
        addr_b  = addr_a | half;
        tw_full = pos << (SW'(LOG2N - 1) - stage_q);
    end

    // Butterfly datapath: t = B*W rounded toward -inf, A' = A+t, B' = A-t.
    always_comb begin
        a_re = mem_re_q[addr_a];
        a_im = mem_im_q[addr_a];
        b_re = mem_re_q[addr_b];
        b_im = mem_im_q[addr_b];
        m_rr = $signed({{TW{b_re[DW-1]}}, b_re}) * $signed({{DW{bus.tw_re[TW-1]}}, bus.tw_re});
        m_ii = $signed({{TW{b_im[DW-1]}}, b_im}) * $signed({{DW{bus.tw_im[TW-1]}}, bus.tw_im});
        m_ri = $signed({{TW{b_re[DW-1]}}, b_re}) * $signed({{DW{bus.tw_im[TW-1]}}, bus.tw_im});
        m_ir = $signed({{TW{b_im[DW-1]}}, b_im}) * $signed({{DW{bus.tw_re[TW-1]}}, bus.tw_re});
        p_re = $signed({m_rr[MW-1], m_rr}) - $signed({m_ii[MW-1], m_ii});
        p_im = $signed({m_ri[MW-1], m_ri}) + $signed({m_ir[MW-1], m_ir});
        // W_0 is +1.0, which the Q1.(TW-1) twiddle format cannot hold: pass B through.
        if (tw_full == '0) begin
            t_re = $signed({{2{b_re[DW-1]}}, b_re});
            t_im = $signed({{2{b_im[DW-1]}}, b_im});
        end else begin
            t_re = (DW+2)'(p_re >>> (TW - 1));
            t_im = (DW+2)'(p_im >>> (TW - 1));
        end
        sum_re = $signed({{2{a_re[DW-1]}}, a_re}) + t_re;
        sum_im = $signed({{2{a_im[DW-1]}}, a_im}) + t_im;
        dif_re = $signed({{2{a_re[DW-1]}}, a_re}) - t_re;
        dif_im = $signed({{2{a_im[DW-1]}}, a_im}) - t_im;
`ifdef FFT_STAGE_SCALE_EN
        wa_re = DW'(sum_re >>> 1);
        wa_im = DW'(sum_im >>> 1);
        wb_re = DW'(dif_re >>> 1);
        wb_im = DW'(dif_im >>> 1);
`else
        wa_re = DW'(sum_re);
        wa_im = DW'(sum_im);
        wb_re = DW'(dif_re);
        wb_im = DW'(dif_im);
`endif
    end

    // Next-state, counter and output decode for IDLE/LOAD/CALC/UNLOAD.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        load_we     = 1'b0;
        calc_we     = 1'b0;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_re_c    = '0;
        out_im_c    = '0;
        out_index_c = '0;
        tw_addr_c   = '0;
        case (state_q)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    load_we = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        stage_d = '0;
                        state_d = S_CALC;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_CALC: begin
                calc_we   = 1'b1;
                tw_addr_c = (LOG2N-1)'(tw_full);
                if (&cnt_q[LOG2N-2:0]) begin
                    cnt_d = '0;
                    if (stage_q == SW'(LOG2N - 1)) begin
                        stage_d = '0;
                        state_d = S_UNLOAD;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_UNLOAD: begin
                out_valid_c = 1'b1;
                out_re_c    = mem_re_q[cnt_q];
                out_im_c    = mem_im_q[cnt_q];
                out_index_c = cnt_q;
                if (bus.out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register; reset aborts any transform in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    // Sample/working array: bit-reversed load writes, or both butterfly outputs together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_we) begin
                mem_re_q[load_addr] <= bus.in_re;
                mem_im_q[load_addr] <= bus.in_im;
            end
            if (calc_we) begin
                mem_re_q[addr_a] <= wa_re;
                mem_im_q[addr_a] <= wa_im;
                mem_re_q[addr_b] <= wb_re;
                mem_im_q[addr_b] <= wb_im;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_re    = out_re_c;
    assign bus.out_im    = out_im_c;
    assign bus.out_index = out_index_c;
    assign bus.tw_addr   = tw_addr_c;
endmodule

// File: tb/tb_fft_iter_engine.sv
// Directed bench for fft_iter_engine at N=8 with a Q1.9 twiddle ROM.
// Expected bins are hand-computed, including the FFT_STAGE_SCALE_EN variant.
module tb_fft_iter_engine;
    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int DW    = 16;
    localparam int TW    = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_iter_engine_if #(.DW(DW), .LOG2N(LOG2N), .TW(TW)) bus ();

    fft_iter_engine #(.N(N), .LOG2N(LOG2N), .DW(DW), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Twiddle ROM W_k = exp(-j*2*pi*k/8) in Q1.9; W_0 is bypassed inside the engine.
    logic signed [TW-1:0] rom_re [4];
    logic signed [TW-1:0] rom_im [4];
    initial begin
        rom_re[0] = 10'sd511;  rom_im[0] = 10'sd0;
        rom_re[1] = 10'sd362;  rom_im[1] = -10'sd362;
        rom_re[2] = 10'sd0;    rom_im[2] = -10'sd512;
        rom_re[3] = -10'sd362; rom_im[3] = -10'sd362;
    end
    assign bus.tw_re = rom_re[bus.tw_addr];
    assign bus.tw_im = rom_im[bus.tw_addr];

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;

    int x_re [N];
    int x_im [N];
    int e_re [N];
    int e_im [N];
    int got_re [N];
    int got_im [N];

    task automatic check(input string tag, input int obs, input int exp_val);
        n_total++;
        if (obs == exp_val) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
    endtask

    // Count done pulses, sampled mid-cycle after the handshake inputs have settled.
    always begin
        @(negedge clk);
        #2;
        if (bus.done === 1'b1) done_cnt++;
    end

    // Fill stimulus and expected bins for a test case.
    task automatic set_case(input int id);
        for (int i = 0; i < N; i++) begin
            x_re[i] = 0; x_im[i] = 0; e_re[i] = 0; e_im[i] = 0;
        end
        case (id)
            0: begin  // impulse at x[0]
                x_re[0] = 100;
`ifdef FFT_STAGE_SCALE_EN
                for (int i = 0; i < N; i++) e_re[i] = 12;
`else
                for (int i = 0; i < N; i++) e_re[i] = 100;
`endif
            end
            1: begin  // DC
                for (int i = 0; i < N; i++) x_re[i] = 10;
`ifdef FFT_STAGE_SCALE_EN
                e_re[0] = 10;
`else
                e_re[0] = 80;
`endif
            end
            2: begin  // impulse at x[1]: exercises every non-trivial twiddle
                x_re[1] = 100;
`ifdef FFT_STAGE_SCALE_EN
                e_re = '{12, 8, 0, -9, -13, -9, 0, 9};
                e_im = '{0, -9, -13, -9, 0, 9, 12, 9};
`else
                e_re = '{100, 70, 0, -71, -100, -70, 0, 71};
                e_im = '{0, -71, -100, -71, 0, 71, 100, 71};
`endif
            end
            default: begin  // full-scale DC, wraps when unscaled
                for (int i = 0; i < N; i++) x_re[i] = 32767;
`ifdef FFT_STAGE_SCALE_EN
                e_re[0] = 32767;
`else
                e_re[0] = -8;
`endif
            end
        endcase
    endtask

    // Pulse start and stream all N samples, optionally idling in_valid every other cycle.
    task automatic start_and_load(input string name, input bit in_stall);
        int n;
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({name, " in_ready"}, int'(bus.in_ready), 1);
        n = 0;
        cyc = 0;
        while (n < N && cyc < 100) begin
            if (in_stall && (cyc % 2 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_re    = 16'sd12345;
                bus.in_im    = -16'sd999;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_re    = DW'(x_re[n]);
                bus.in_im    = DW'(x_im[n]);
                if (bus.in_ready) n++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check({name, " load_count"}, n, N);
    endtask

    // Full transform: load, time CALC, unload with optional stall on one bin, compare bins.
    task automatic run_fft(input string name, input bit in_stall, input int stall_bin,
                           input bit poke_start);
        int calc;
        int k;
        int cyc;
        int hold_cnt;
        int hold_re;
        int hold_im;
        done_cnt = 0;
        start_and_load(name, in_stall);
        if (poke_start) bus.start = 1'b1;
        calc = 0;
        while (!bus.out_valid && calc < 100) begin
            calc++;
            @(negedge clk);
        end
        check({name, " calc_cycles"}, calc, 12);
        check({name, " busy_unload"}, int'(bus.busy), 1);
        check({name, " tw_addr_unload"}, int'(bus.tw_addr), 0);
        k = 0;
        cyc = 0;
        hold_cnt = 0;
        hold_re = 0;
        hold_im = 0;
        while (k < N && cyc < 100) begin
            if (k == stall_bin && hold_cnt < 3) begin
                bus.out_ready = 1'b0;
                #1;
                if (hold_cnt == 0) begin
                    hold_re = int'(bus.out_re);
                    hold_im = int'(bus.out_im);
                end else begin
                    check({name, " hold_re"}, int'(bus.out_re), hold_re);
                    check({name, " hold_im"}, int'(bus.out_im), hold_im);
                    check({name, " hold_index"}, int'(bus.out_index), k);
                end
                hold_cnt++;
            end else begin
                bus.out_ready = 1'b1;
                #1;
                check({name, " out_index"}, int'(bus.out_index), k);
                check({name, " done_level"}, int'(bus.done), (k == N - 1) ? 1 : 0);
                got_re[k] = int'(bus.out_re);
                got_im[k] = int'(bus.out_im);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check({name, " unload_count"}, k, N);
        #1;
        check({name, " busy_after"}, int'(bus.busy), 0);
        check({name, " done_pulses"}, done_cnt, 1);
        for (int i = 0; i < N; i++) begin
            $display("%s bin %0d: (%0d,%0d) expected (%0d,%0d)",
                     name, i, got_re[i], got_im[i], e_re[i], e_im[i]);
            check($sformatf("%s re[%0d]", name, i), got_re[i], e_re[i]);
            check($sformatf("%s im[%0d]", name, i), got_im[i], e_im[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", int'(bus.busy), 0);
        check("reset in_ready", int'(bus.in_ready), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset done", int'(bus.done), 0);
        check("reset tw_addr", int'(bus.tw_addr), 0);
        check("reset out_re", int'(bus.out_re), 0);
        check("reset out_im", int'(bus.out_im), 0);
        check("reset out_index", int'(bus.out_index), 0);
        rst = 1'b0;

        set_case(0);
        run_fft("impulse", 1'b0, -1, 1'b0);
        set_case(1);
        run_fft("dc", 1'b0, -1, 1'b0);
        set_case(2);
        run_fft("shift", 1'b0, -1, 1'b0);
        run_fft("shift_bp", 1'b1, 5, 1'b1);
        set_case(3);
        run_fft("overflow", 1'b0, -1, 1'b0);

        // Abort mid-CALC with a one-cycle reset, then confirm a clean transform.
        set_case(2);
        start_and_load("abort", 1'b0);
        repeat (5) @(negedge clk);
        check("abort busy_calc", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", int'(bus.busy), 0);
        check("abort out_valid", int'(bus.out_valid), 0);
        check("abort tw_addr", int'(bus.tw_addr), 0);
        check("abort in_ready", int'(bus.in_ready), 0);
        set_case(0);
        run_fft("after_abort", 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
